dibit_tx: RTL and testbench
===========================

DIBIT_TX -- requirements
Module: dibit_tx

Interface
REQ-001 Parameter: WIDTH, 8, payload bits per frame; SHALL be even and >= 2.
REQ-002 Port: CLK1  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port: RST  input  1  reset, asynchronous, active-low.
REQ-004 Port: in_data  input  WIDTH  payload word offered by the producer.
REQ-005 Port: in_valid  input  1  producer asserts when in_data holds a word to send.
REQ-006 Port: in_ready  output  1  block can accept a word this cycle.
REQ-007 Port: D1  output  1  serial line, high bit of each transmitted dibit.
REQ-008 Port: D2  output  1  serial line, low bit of each transmitted dibit.
REQ-009 Port: busy  output  1  frame in progress.
REQ-010 Port: frame_cnt  output  4  count of completed frames, wraps modulo 16.

Function
REQ-011 Frame SHALL be, one dibit per cycle on {D1,D2}: START (1,1); WIDTH/2 data dibits, MSB pair first; PARITY (D1 = XOR of all word bits, D2 = its inverse).
REQ-012 States SHALL be IDLE, START, DATA and PAR.
REQ-013 in_ready SHALL equal 1 in IDLE and 0 in every other state.
REQ-014 Accept: a rising edge with in_valid=1 and in_ready=1 SHALL capture in_data into an internal shift register and move IDLE->START.
REQ-015 After acceptance, changes to in_data and in_valid SHALL have no effect until the block returns to IDLE.
REQ-016 in_valid=1 while in_ready=0 SHALL be ignored; no word is queued.
REQ-017 D1, D2, busy and in_ready SHALL be registered, not combinational from inputs.
REQ-018 Timing, acceptance at edge k: START after k; data dibit i after k+1+i for i = 0 .. WIDTH/2-1; PAR after k+1+WIDTH/2; IDLE after k+2+WIDTH/2.
REQ-019 For WIDTH=8 a frame SHALL occupy exactly 6 cycles of busy=1.
REQ-020 Transitions: START->DATA unconditionally; DATA->DATA while the dibit counter < WIDTH/2-1; DATA->PAR when it reaches WIDTH/2-1; PAR->IDLE unconditionally.
REQ-021 Back-to-back: a word presented continuously SHALL be accepted on the first edge in IDLE, giving exactly one idle (0,0) cycle between frames.
REQ-022 In IDLE, D1=0, D2=0 and busy=0.
REQ-023 The PAR->IDLE transition SHALL increment frame_cnt by 1, wrapping from 15 to 0.
REQ-024 Parity SHALL be computed from the captured word, not from the live in_data.

Reset
REQ-025 RST=0 SHALL immediately, without waiting for a clock edge, force: state IDLE, D1=0, D2=0, busy=0, in_ready=1, frame_cnt=0, shift register and dibit counter to 0.
REQ-026 Reset during a frame SHALL abort it with no PARITY dibit and no frame_cnt increment.
REQ-027 After RST returns to 1, the first accept SHALL be possible on the first rising edge.

Structure
REQ-028 A shared package SHALL hold the state encoding (2-bit), the START symbol, the default WIDTH and the frame_cnt width.
REQ-029 The shift register with its dibit counter SHALL be a single sub-module named dibit_shreg (load, shift-by-2, exposes top dibit and last flag); the FSM and parity live in dibit_tx.

Verification
REQ-030 Reset, then in_data=8'hB4 with in_valid=1 for one cycle -> {D1,D2} = 11,10,11,01,00,01; busy high for 6 cycles; frame_cnt 0->1.
REQ-031 in_data=8'h01 -> 11,00,00,00,01,10 (parity 1); after it completes, in_ready=1 and {D1,D2}=00.
REQ-032 in_valid held at 1 with data 8'hFF then 8'h00 -> frames separated by exactly one 00 idle cycle; the second frame's PAR dibit = 01.
REQ-033 Change in_data from 8'hB4 to 8'h4B in the middle of the frame -> transmitted dibits and parity still those of 8'hB4.
REQ-034 Assert RST=0 asynchronously during the second data dibit -> D1=D2=0 and busy=0 before the next CLK1 edge; frame_cnt unchanged at 0.
REQ-035 Send 17 frames -> frame_cnt reads 1 (wrap past 15).

Source files
------------

// File: rtl/dibit_tx_pkg.sv
// Shared definitions for the dibit serial transmitter: state encoding,
// frame symbols, default payload width and frame counter width.
package dibit_tx_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int FCNT_W    = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_PAR   = 2'd3;

  localparam logic [1:0] START_SYM = 2'b11;
  localparam logic [1:0] IDLE_SYM  = 2'b00;

  // Parity dibit: high line carries the parity, low line its inverse.
  function automatic logic [1:0] parity_dibit(input logic p);
    return {p, ~p};
  endfunction

endpackage

// File: rtl/dibit_shreg.sv
// Payload shift register for the dibit transmitter. Loads a word, shifts it
// out two bits at a time MSB first, and counts the dibits shifted out.
module dibit_shreg
  import dibit_tx_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_data,
  output logic [1:0]       top,
  output logic             last
);

  localparam int CW = $clog2(WIDTH / 2 + 1);
  // Once every data dibit has been shifted out, the dibit currently on the
  // line (index cnt-1) is the final one, i.e. index WIDTH/2-1.
  localparam logic [CW-1:0] ALL_OUT = CW'(WIDTH / 2);

  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;

  // Load a fresh word or shift the next dibit towards the top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr  <= '0;
      cnt <= '0;
    end else if (load) begin
      sr  <= load_data;
      cnt <= '0;
    end else if (shift) begin
      sr  <= sr << 2;
      cnt <= cnt + 1'b1;
    end
  end

  assign top  = sr[WIDTH-1 -: 2];
  assign last = (cnt == ALL_OUT);

endmodule

// File: rtl/dibit_tx.sv
// Dibit serial transmitter: frames a payload word as START, WIDTH/2 data
// dibits (MSB pair first) and a parity dibit on the D1/D2 line pair.
module dibit_tx
  import dibit_tx_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic              CLK1,
  input  logic              RST,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              D1,
  output logic              D2,
  output logic              busy,
  output logic [FCNT_W-1:0] frame_cnt
);

  logic [1:0] state;
  logic       par_bit;
  logic       load;
  logic       shift;
  logic [1:0] top_dibit;
  logic       last;

  // in_ready is high exactly in IDLE, so this is the accept handshake.
  assign load  = in_ready & in_valid;
  // The first shift happens while START is on the line, so the top of the
  // register always holds the next data dibit to send.
  assign shift = (state == ST_START) | ((state == ST_DATA) & ~last);

  dibit_shreg #(
    .WIDTH (WIDTH)
  ) u_shreg (
    .clk       (CLK1),
    .rst_n     (RST),
    .load      (load),
    .shift     (shift),
    .load_data (in_data),
    .top       (top_dibit),
    .last      (last)
  );

  // Frame sequencer: drives registered line outputs, status and frame count.
  always_ff @(posedge CLK1 or negedge RST) begin
    if (!RST) begin
      state     <= ST_IDLE;
      D1        <= 1'b0;
      D2        <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
      par_bit   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load) begin
            state    <= ST_START;
            {D1, D2} <= START_SYM;
            busy     <= 1'b1;
            in_ready <= 1'b0;
            // Same value the shift register captures on this edge.
            par_bit  <= ^in_data;
          end
        end
        ST_START: begin
          state    <= ST_DATA;
          {D1, D2} <= top_dibit;
        end
        ST_DATA: begin
          if (last) begin
            state    <= ST_PAR;
            {D1, D2} <= parity_dibit(par_bit);
          end else begin
            {D1, D2} <= top_dibit;
          end
        end
        default: begin
          state     <= ST_IDLE;
          {D1, D2}  <= IDLE_SYM;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
          frame_cnt <= frame_cnt + FCNT_W'(1);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dibit_tx.sv
// Directed bench for dibit_tx (WIDTH=8): table of words with hand-computed
// frames, plus hand-written reset-abort, back-to-back and mid-frame sequences.
module tb_dibit_tx;

  logic       CLK1 = 1'b0;
  logic       RST  = 1'b1;
  logic [7:0] in_data  = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       D1;
  logic       D2;
  logic       busy;
  logic [3:0] frame_cnt;

  int         tests  = 0;
  int         failed = 0;
  logic [3:0] exp_cnt = 4'd0;
  int         nframes = 0;

  typedef struct {
    logic [7:0]  data;
    logic [11:0] frame;   // six dibits: START, d0..d3, PAR
  } vec_t;

  vec_t vecs [8];

  dibit_tx #(
    .WIDTH (8)
  ) dut (
    .CLK1      (CLK1),
    .RST       (RST),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .D1        (D1),
    .D2        (D2),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  always #5 CLK1 = ~CLK1;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Offers one word, then checks all six dibits and the return to IDLE.
  // Called at a negedge; returns at the negedge of the idle cycle so that a
  // following call with in_valid still high is accepted back-to-back.
  task automatic run_frame(input logic [7:0] data, input logic [7:0] late,
                           input logic keep, input logic [11:0] frame);
    int busy_n;
    busy_n   = 0;
    in_data  = data;
    in_valid = 1'b1;
    check("ready_before", in_ready, 1);
    @(posedge CLK1);
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK1);
      if (i == 0) in_valid = keep;
      if (i == 2) in_data = late;
      check($sformatf("dibit%0d_%02h", i, data), {D1, D2}, frame[11-2*i -: 2]);
      check("ready_low", in_ready, 0);
      if (busy) busy_n++;
    end
    @(negedge CLK1);
    exp_cnt = exp_cnt + 4'd1;
    nframes++;
    check("busy_cycles", busy_n, 6);
    check("idle_line", {D1, D2}, 2'b00);
    check("idle_busy", busy, 0);
    check("idle_ready", in_ready, 1);
    check("frame_cnt", frame_cnt, exp_cnt);
  endtask

  initial begin
    vecs[0] = '{8'hB4, 12'b11_10_11_01_00_01};
    vecs[1] = '{8'h01, 12'b11_00_00_00_01_10};
    vecs[2] = '{8'hFF, 12'b11_11_11_11_11_01};
    vecs[3] = '{8'h00, 12'b11_00_00_00_00_01};
    vecs[4] = '{8'hA5, 12'b11_10_10_01_01_01};
    vecs[5] = '{8'h80, 12'b11_10_00_00_00_10};
    vecs[6] = '{8'h7F, 12'b11_01_11_11_11_10};
    vecs[7] = '{8'h4B, 12'b11_01_00_10_11_01};

    // Asynchronous reset before any clock edge
    #2 RST = 1'b0;
    #1;
    check("rst_line", {D1, D2}, 2'b00);
    check("rst_busy", busy, 0);
    check("rst_ready", in_ready, 1);
    check("rst_cnt", frame_cnt, 0);
    @(negedge CLK1);
    RST = 1'b1;

    // Abort during the second data dibit of 8'hB4
    @(negedge CLK1);
    in_data  = 8'hB4;
    in_valid = 1'b1;
    @(posedge CLK1);
    @(negedge CLK1);
    in_valid = 1'b0;
    check("abort_start", {D1, D2}, 2'b11);
    @(negedge CLK1);
    check("abort_d0", {D1, D2}, 2'b10);
    @(negedge CLK1);
    check("abort_d1", {D1, D2}, 2'b11);
    #2 RST = 1'b0;
    #1;
    check("abort_line", {D1, D2}, 2'b00);
    check("abort_busy", busy, 0);
    check("abort_ready", in_ready, 1);
    check("abort_cnt", frame_cnt, 0);
    @(negedge CLK1);
    RST = 1'b1;

    // First frame accepted on the first edge after reset release
    run_frame(vecs[0].data, vecs[0].data, 1'b0, vecs[0].frame);
    check("first_cnt", frame_cnt, 1);

    // Table of single frames with idle gaps
    for (int v = 1; v < 8; v++) begin
      @(negedge CLK1);
      check("gap_line", {D1, D2}, 2'b00);
      run_frame(vecs[v].data, vecs[v].data, 1'b0, vecs[v].frame);
    end

    // Back-to-back: valid held high, FF then 00 (00 offered during FF frame)
    @(negedge CLK1);
    run_frame(8'hFF, 8'h00, 1'b1, 12'b11_11_11_11_11_01);
    run_frame(8'h00, 8'h00, 1'b0, 12'b11_00_00_00_00_01);

    // Mid-frame change of in_data must not alter data or parity
    @(negedge CLK1);
    run_frame(8'hB4, 8'h4B, 1'b0, 12'b11_10_11_01_00_01);

    // Keep sending until 17 completed frames to see the wrap
    while (nframes < 17) begin
      @(negedge CLK1);
      run_frame(vecs[nframes % 8].data, vecs[nframes % 8].data, 1'b0,
                vecs[nframes % 8].frame);
      if (nframes == 16) check("cnt_at_16", frame_cnt, 0);
    end
    check("cnt_wrap", frame_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
